// File: rtl/random_source.sv
// rtl/random_source.sv - decimated Galois LFSR random source with warmup and seed load
`timescale 1ns/1ps
module random_source #(
  parameter logic [31:0] SEED   = 32'hACE1_2468,
  parameter logic [31:0] TAPS   = 32'h8020_0003,
  parameter int          DECIM  = 8,
  parameter int          WARMUP = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        seed_load,
  input  logic [31:0] seed_data,
  output logic [31:0] random_out,
  output logic        sample_tick,
  output logic        seed_zero,
  output logic        lockup_err
);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Last count values; WARM_LAST is only meaningful when WARMUP is nonzero.
  localparam logic [7:0] DCNT_LAST = 8'(DECIM - 1);
  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);
  localparam bit         NO_WARMUP = (WARMUP == 0);

  state_t      state;
  state_t      state_next;
  logic [31:0] lfsr;
  logic [31:0] lfsr_d;
  logic [31:0] lfsr_step;
  logic [7:0]  dcnt;
  logic [7:0]  dcnt_d;
  logic [7:0]  warm_cnt;
  logic [7:0]  warm_d;
  logic [31:0] random_d;
  logic        tick_d;
  logic        seed_zero_d;
  logic        lockup_d;

  // One Galois step: shift right, fold the taps back in when a one falls out.
  assign lfsr_step = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_WARMUP;
    end else begin
      state <= state_next;
    end
  end

  // Next state and datapath updates; seed_load beats lockup recovery beats normal stepping.
  always_comb begin
    state_next  = state;
    lfsr_d      = lfsr;
    dcnt_d      = dcnt;
    warm_d      = warm_cnt;
    random_d    = random_out;
    tick_d      = 1'b0;
    seed_zero_d = seed_zero;
    lockup_d    = lockup_err;

    if (seed_load) begin
      if (seed_data == 32'h0) begin
        lfsr_d      = SEED;
        seed_zero_d = 1'b1;
      end else begin
        lfsr_d = seed_data;
      end
      dcnt_d     = 8'd0;
      warm_d     = 8'd0;
      state_next = ST_WARMUP;
    end else if (lfsr == 32'h0) begin
      // An all-zero register would never leave zero; reseed and skip this step.
      lfsr_d   = SEED;
      lockup_d = 1'b1;
    end else begin
      case (state)
        ST_WARMUP: begin
          if (NO_WARMUP) begin
            state_next = enable ? ST_RUN : ST_HOLD;
          end else begin
            lfsr_d = lfsr_step;
            warm_d = warm_cnt + 8'd1;
            if (warm_cnt == WARM_LAST) begin
              state_next = enable ? ST_RUN : ST_HOLD;
            end
          end
        end
        ST_RUN: begin
          if (enable) begin
            lfsr_d = lfsr_step;
            if (dcnt == DCNT_LAST) begin
              dcnt_d   = 8'd0;
              random_d = lfsr_step;
              tick_d   = 1'b1;
            end else begin
              dcnt_d = dcnt + 8'd1;
            end
          end else begin
            state_next = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (enable) begin
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next = ST_WARMUP;
        end
      endcase
    end
  end

  // Datapath and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr        <= SEED;
      dcnt        <= 8'd0;
      warm_cnt    <= 8'd0;
      random_out  <= 32'h0;
      sample_tick <= 1'b0;
      seed_zero   <= 1'b0;
      lockup_err  <= 1'b0;
    end else begin
      lfsr        <= lfsr_d;
      dcnt        <= dcnt_d;
      warm_cnt    <= warm_d;
      random_out  <= random_d;
      sample_tick <= tick_d;
      seed_zero   <= seed_zero_d;
      lockup_err  <= lockup_d;
    end
  end

endmodule

// File: doc/random_source.md
RANDOM_SOURCE -- requirements
Module: random_source

Interface
REQ-001 Parameters: SEED, default 32'hACE1_2468, reset/fallback LFSR state (nonzero).
REQ-002 Parameters: TAPS, default 32'h8020_0003, Galois feedback mask (x^32+x^22+x^2+x+1).
REQ-003 Parameters: DECIM, default 8, LFSR steps per published sample; legal range 1..256.
REQ-004 Parameters: WARMUP, default 64, discard steps after reset or seed load; legal range 0..255.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 Port: clk  in  1  sole clock, all state on rising edge.
REQ-007 Port: reset  in  1  async active-high reset.
REQ-008 Port: enable  in  1  run/step permission in RUN; ignored in WARMUP.
REQ-009 Port: seed_load  in  1  single-cycle request to load seed_data.
REQ-010 Port: seed_data  in  32  seed value, sampled when seed_load=1.
REQ-011 Port: random_out  out  32  published sample; drives the 32-bit PIO input port; registered.
REQ-012 Port: sample_tick  out  1  one-cycle pulse coincident with each new random_out value.
REQ-013 Port: seed_zero  out  1  sticky flag: a zero seed was substituted.
REQ-014 Port: lockup_err  out  1  sticky flag: LFSR state reached zero and was recovered.

Function
REQ-015 LFSR step: lfsr_next = lfsr[0] ? ((lfsr>>1) ^ TAPS) : (lfsr>>1); 32-bit, no width growth.
REQ-016 FSM states: WARMUP, RUN, HOLD; exactly one active.
REQ-017 WARMUP: LFSR steps every cycle regardless of enable; warm counter increments; random_out and sample_tick held; after WARMUP steps -> RUN if enable=1, else HOLD; WARMUP=0 -> leave on the first cycle without stepping.
REQ-018 RUN: LFSR steps every cycle; enable=0 -> HOLD, no step in that cycle.
REQ-019 HOLD: LFSR, decimation counter and random_out frozen; enable=1 -> RUN, stepping resumes the following cycle.
REQ-020 Decimation counter dcnt counts 0..DECIM-1, advancing only on RUN steps.
REQ-021 At dcnt=DECIM-1: random_out <= lfsr_next, sample_tick=1 for one cycle, dcnt wraps to 0.
REQ-022 sample_tick is registered with random_out and is never high in two consecutive cycles unless DECIM=1.
REQ-023 seed_load has priority over all other events in any state.
REQ-024 seed_load effect: lfsr <= seed_data (or SEED if seed_data=0, setting seed_zero); dcnt and warm counter cleared; -> WARMUP.
REQ-025 seed_load during WARMUP restarts the warmup count.
REQ-026 random_out keeps its last value across seed_load and warmup.
REQ-027 If lfsr is ever zero: next cycle lfsr <= SEED and lockup_err set; the step is skipped.
REQ-028 Sticky flags clear only on reset.
REQ-029 The block holds no combinational path from inputs to outputs.

Reset
REQ-030 reset=1: lfsr=SEED, dcnt=0, warm counter=0, state=WARMUP, random_out=32'h0, sample_tick=0, seed_zero=0, lockup_err=0.
REQ-031 Reset asserted mid-operation aborts immediately; no partial sample is published.
REQ-032 After reset deassertion the block behaves as after a seed_load of SEED.

Verification
REQ-033 Step sequence: WARMUP=0, DECIM=1, enable=1, seed_load with 32'h0000_0001 -> random_out = 32'h8020_0003, 32'hC030_0002, 32'h6018_0001 on successive cycles, with sample_tick high on each.
REQ-034 Decimation and hold: DECIM=4 -> sample_tick exactly every 4th cycle; enable dropped for 10 cycles mid-count -> no tick, random_out stable; after re-enable the remaining count completes.
REQ-035 Zero seed: seed_load with 32'h0 -> seed_zero=1; sequence identical to a load of SEED.
REQ-036 Warmup: WARMUP=64 after reset -> random_out=0 and sample_tick=0 for 64 cycles; first tick at cycle 64+DECIM.
REQ-037 seed_load simultaneous with a tick, plus seed_load asserted at warmup cycle 30 -> seed_load wins, no tick, warmup restarts from 0.
REQ-038 Reset pulse mid-RUN -> all outputs return to REQ-030 values asynchronously.
